// File: rtl/seq_shift_unit.sv
// Iterative SLL/SRL/SRA unit: shifts an XLEN-bit operand by up to STEP positions per clock,
// with valid/ready handshakes on the request and result sides.
module seq_shift_unit #(
  parameter int XLEN = 32,
  parameter int STEP = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         data_in,
  input  logic [$clog2(XLEN)-1:0] shift_amt,
  input  logic [1:0]              shift_type,
  input  logic                    kill,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         data_out
);

  localparam int AW = $clog2(XLEN);
  localparam logic [AW-1:0] STEP_A = AW'(STEP);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]      state;
  logic [XLEN-1:0] acc;
  logic [AW-1:0]   rem;
  logic [1:0]      typ;
  logic [AW-1:0]   step_d;

  // One partial shift; type 10 and 11 are both arithmetic right.
  function automatic logic [XLEN-1:0] shift_step(input logic [XLEN-1:0] a,
                                                 input logic [1:0]      t,
                                                 input logic [AW-1:0]   d);
    logic signed [XLEN-1:0] a_s;
    logic [XLEN-1:0]        r;
    a_s = a;
    case (t)
      2'b00:   r = a << d;
      2'b01:   r = a >> d;
      default: r = a_s >>> d;
    endcase
    return r;
  endfunction

  always_comb begin
    step_d = (rem < STEP_A) ? rem : STEP_A;
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign data_out  = acc;

  // Control and operand registers; reset wins over kill, kill wins over handshakes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      rem   <= '0;
      typ   <= '0;
    end else if (kill) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc   <= data_in;
            rem   <= shift_amt;
            typ   <= shift_type;
            state <= (shift_amt == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          acc <= shift_step(acc, typ, step_d);
          rem <= rem - step_d;
          if (rem == step_d) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Randomized and directed bench for seq_shift_unit: a latency/result model computed from the
// full shift distance is compared against the DUT every cycle.
module tb_seq_shift_unit;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, kill, out_valid, out_ready;
  logic [31:0] data_in, data_out;
  logic [4:0]  shift_amt;
  logic [1:0]  shift_type;

  int checks = 0;
  int failures = 0;

  longint      cyc = 0;
  bit          m_pend;
  bit          m_zero;
  longint      m_vc;
  logic [31:0] m_res;

  always #5 clk = ~clk;

  seq_shift_unit #(.XLEN(32), .STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .shift_amt(shift_amt), .shift_type(shift_type), .kill(kill),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out)
  );

  function automatic logic [31:0] ref_shift(input logic [31:0] x, input int amt,
                                            input logic [1:0] t);
    logic signed [31:0] xs;
    xs = x;
    if (t == 2'b00) return x << amt;
    if (t == 2'b01) return x >> amt;
    return xs >>> amt;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Compare current outputs with the model, then advance one clock with the driven inputs.
  task automatic cycle();
    bit ev;
    int a;
    ev = m_pend && (cyc >= m_vc);
    chk("in_ready", {31'b0, in_ready}, {31'b0, !m_pend});
    chk("out_valid", {31'b0, out_valid}, {31'b0, ev});
    if (ev) chk("data_out", data_out, m_res);
    else if (m_zero) chk("data_out_zero", data_out, 32'h0);
    if (!rst_n) begin
      m_pend = 0;
      m_zero = 1;
    end else if (kill) begin
      m_pend = 0;
    end else if (!m_pend) begin
      if (in_valid) begin
        a      = int'(shift_amt);
        m_pend = 1;
        m_zero = 0;
        m_res  = ref_shift(data_in, a, shift_type);
        m_vc   = cyc + 1 + (a + 3) / 4;
      end
    end else if (ev && out_ready) begin
      m_pend = 0;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic run_op(input logic [31:0] d, input logic [4:0] a, input logic [1:0] t,
                        input int stall, output int lat, output logic [31:0] res);
    in_valid = 1; data_in = d; shift_amt = a; shift_type = t; kill = 0;
    out_ready = (stall == 0);
    cycle();
    in_valid = 0;
    data_in = $urandom; shift_amt = 5'($urandom); shift_type = 2'($urandom);
    lat = 1;
    while (!out_valid && lat < 20) begin
      cycle();
      lat++;
    end
    if (lat >= 20) chk("op_timeout", 32'(lat), 32'd0);
    res = data_out;
    for (int i = 0; i < stall; i++) begin
      chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
      chk("stall_data", data_out, res);
      cycle();
    end
    out_ready = 1;
    cycle();
  endtask

  initial begin
    int lat;
    logic [31:0] res;
    rst_n = 0; in_valid = 0; kill = 0; out_ready = 1;
    data_in = '0; shift_amt = '0; shift_type = '0;
    m_pend = 0; m_zero = 1; m_vc = 0; m_res = '0;
    @(posedge clk); cyc++; #1;
    cycle();
    rst_n = 1;
    cycle();

    run_op(32'hDEADBEEF, 5'd0, 2'b00, 0, lat, res);
    chk("sll0_lat", 32'(lat), 32'd1);
    chk("sll0_res", res, 32'hDEADBEEF);
    run_op(32'h80000000, 5'd31, 2'b11, 0, lat, res);
    chk("sra31_lat", 32'(lat), 32'd9);
    chk("sra31_res", res, 32'hFFFFFFFF);
    run_op(32'h80000000, 5'd31, 2'b01, 0, lat, res);
    chk("srl31_res", res, 32'h00000001);
    run_op(32'h00000001, 5'd5, 2'b00, 0, lat, res);
    chk("sll5_lat", 32'(lat), 32'd3);
    chk("sll5_res", res, 32'h00000020);
    run_op(32'hF0000000, 5'd4, 2'b10, 3, lat, res);
    chk("sra10_lat", 32'(lat), 32'd2);
    chk("sra10_res", res, 32'hFF000000);

    // Kill in the second SHIFT cycle of a by-31 op.
    in_valid = 1; data_in = 32'h12345678; shift_amt = 5'd31; shift_type = 2'b01;
    cycle();
    in_valid = 0;
    cycle();
    kill = 1;
    cycle();
    kill = 0;
    chk("kill_in_ready", {31'b0, in_ready}, 32'd1);
    for (int i = 0; i < 10; i++) cycle();

    // Kill in IDLE with a request present: not accepted.
    in_valid = 1; kill = 1; shift_amt = 5'd3; data_in = 32'h1;
    cycle();
    in_valid = 0; kill = 0;
    chk("kill_idle_ready", {31'b0, in_ready}, 32'd1);
    cycle();

    // Kill in DONE while consuming.
    in_valid = 1; data_in = 32'h0000000F; shift_amt = 5'd2; shift_type = 2'b00;
    cycle();
    in_valid = 0;
    while (!out_valid && cyc < 2000) cycle();
    chk("done_res", data_out, 32'h0000003C);
    kill = 1; out_ready = 1;
    cycle();
    kill = 0;
    cycle();

    // Reset for one cycle in the middle of a shift.
    in_valid = 1; data_in = 32'hCAFEF00D; shift_amt = 5'd20; shift_type = 2'b11;
    cycle();
    in_valid = 0;
    cycle();
    cycle();
    rst_n = 0;
    cycle();
    rst_n = 1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_data", data_out, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    run_op(32'h00000F00, 5'd8, 2'b01, 0, lat, res);
    chk("post_rst_lat", 32'(lat), 32'd3);
    chk("post_rst_res", res, 32'h0000000F);

    // Randomized traffic with occasional kill and reset.
    for (int i = 0; i < 1500; i++) begin
      in_valid   = ($urandom_range(0, 99) < 60);
      out_ready  = ($urandom_range(0, 99) < 70);
      kill       = ($urandom_range(0, 99) < 4);
      rst_n      = !($urandom_range(0, 199) == 0);
      data_in    = $urandom;
      shift_amt  = 5'($urandom);
      shift_type = 2'($urandom);
      cycle();
    end
    rst_n = 1; kill = 0; in_valid = 0; out_ready = 1;
    for (int i = 0; i < 12; i++) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
